mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-fetch side and the data-memory side of the pipelined processor. Sequences one fixed-latency memory transaction at a time through an IDLE/BUSY/DONE state machine. Returns read data and a one-cycle completion pulse to the winning requester, and stalls the other. The block sits between the fetch/memory stages (or their cache controllers) and the memory model.

---
 rtl/mem_arb_pkg.sv | 44 ++++
 rtl/mem_arbiter_lat_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Includes the arbitration priority helper used by the top level.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // D is the older instruction and wins unless the I side is being forced through.
    function automatic owner_t pick_owner(input logic ireq, input logic dreq, input logic force_i);
        owner_t win;
        if (dreq && !force_i) begin
            win = OWN_D;
        end else if (ireq) begin
            win = OWN_I;
        end else begin
            win = OWN_D;
        end
        return win;
    endfunction

    // Write data is only carried onto the memory port for writes.
    function automatic logic [DATA_W-1:0] latch_wdata(input logic wr, input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] val;
        if (wr) begin
            val = wdata;
        end else begin
            val = {DATA_W{1'b0}};
        end
        return val;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// lat_counter: loads 1 on start, counts up to MEM_LAT, flags the terminal
// cycle and then parks at 0 until the next start.
module lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0] count_r;

    // Count register; start takes priority so a new transaction always begins at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (start) begin
            count_r <= CNT_W'(1);
        end else if (count_r == LAT_C) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == LAT_C);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between fetch (I) and data (D).
// Optional I-side starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 4,
    parameter int MAX_D_WINS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_r;
    arb_state_t        state_s;
    owner_t            owner_r;
    owner_t            grant_s;
    logic              start_s;
    logic              capture_s;
    logic              terminal_s;
    logic              force_i_s;
    logic              wr_r;
    logic              mem_en_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_done_r;
    logic              d_done_r;

    lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .terminal (terminal_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int WIN_W = $clog2(MAX_D_WINS + 1);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(MAX_D_WINS);

    logic [WIN_W-1:0] d_wins_r;

    assign force_i_s = (d_wins_r == WIN_MAX) && i_req && d_req;

    // Consecutive D grants taken while I was waiting; any other grant clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            d_wins_r <= {WIN_W{1'b0}};
        end else if (start_s) begin
            if ((grant_s == OWN_D) && i_req) begin
                if (d_wins_r != WIN_MAX) begin
                    d_wins_r <= d_wins_r + WIN_W'(1);
                end else begin
                    d_wins_r <= d_wins_r;
                end
            end else begin
                d_wins_r <= {WIN_W{1'b0}};
            end
        end else begin
            d_wins_r <= d_wins_r;
        end
    end
`else
    localparam int unused_max_d_wins = MAX_D_WINS;

    assign force_i_s = 1'b0;
`endif

    assign grant_s = pick_owner(i_req, d_req, force_i_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus the start/capture strobes; requests only matter in IDLE
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req || d_req) begin
                    state_s = BUSY;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (terminal_s) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Transaction latch, memory strobes, read-data capture and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r     <= OWN_D;
            wr_r        <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
        end else begin
            mem_en_r <= start_s;
            mem_wr_r <= start_s && (grant_s == OWN_D) && d_wr;
            i_done_r <= capture_s && (owner_r == OWN_I);
            d_done_r <= capture_s && (owner_r == OWN_D);
            if (start_s) begin
                owner_r <= grant_s;
                if (grant_s == OWN_D) begin
                    wr_r        <= d_wr;
                    mem_addr_r  <= d_addr;
                    mem_wdata_r <= latch_wdata(d_wr, d_wdata);
                end else begin
                    wr_r        <= 1'b0;
                    mem_addr_r  <= i_addr;
                    mem_wdata_r <= {DATA_W{1'b0}};
                end
            end
            if (capture_s && !wr_r) begin
                if (owner_r == OWN_I) begin
                    i_rdata_r <= mem_rdata;
                end else begin
                    d_rdata_r <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign i_done    = i_done_r;
    assign d_done    = d_done_r;
    assign i_stall   = i_req & ~i_done_r;
    assign d_stall   = d_req & ~d_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=4 / MAX_D_WINS=2 instance plus a
// MEM_LAT=1 instance; grant order expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT  = 4;
    localparam int MAXW = 2;

    typedef struct packed {
        owner_t      side;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr;

    logic        i_req1, d_req1, d_wr1;
    logic [15:0] i_addr1, d_addr1, d_wdata1;
    logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_done1, i_stall1, d_done1, d_stall1, mem_en1, mem_wr1;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    mem_arbiter #(.MEM_LAT(LAT), .MAX_D_WINS(MAXW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1), .MAX_D_WINS(MAXW)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1), .i_stall(i_stall1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_done(d_done1), .d_stall(d_stall1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0010) begin
            return 16'hBEEF;
        end
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: data is only valid in the MEM_LAT-th cycle after mem_en rises
    logic [3:0] bcnt;
    logic [3:0] eff_cnt;
    always @(posedge clk) begin
        if (rst) bcnt <= 4'd0;
        else if (mem_en) bcnt <= 4'd2;
        else if (bcnt != 4'd0 && bcnt != 4'd15) bcnt <= bcnt + 4'd1;
    end
    assign eff_cnt    = mem_en ? 4'd1 : bcnt;
    assign mem_rdata  = (eff_cnt == 4'(LAT)) ? mem_fn(mem_addr) : 16'hDEAD;
    assign mem_rdata1 = mem_en1 ? mem_fn(mem_addr1) : 16'hDEAD;

    logic [69:0] outs0, outs1;
    assign outs0 = {mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata, i_done, d_done, i_stall, d_stall};
    assign outs1 = {mem_en1, mem_wr1, mem_addr1, mem_wdata1, i_rdata1, d_rdata1, i_done1, d_done1, i_stall1, d_stall1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        i_req1 = 1'b0; d_req1 = 1'b0; d_wr1 = 1'b0; i_addr1 = 16'h0; d_addr1 = 16'h0; d_wdata1 = 16'h0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (outs0 !== 70'd0) $display("FAIL reset_outputs: got %h want 0", outs0); else pass_cnt++;
        total_cnt++;
        if (outs1 !== 70'd0) $display("FAIL reset_outputs_lat1: got %h want 0", outs1); else pass_cnt++;
        step();
    endtask

    task automatic test_i_read();
        int   en_cnt;
        int   done_cyc;
        bit   stall_ok;
        exp_t e;
        exp_t got;
        en_cnt = 0; done_cyc = -1; stall_ok = 1'b1;
        sb.delete();
        sb.push_back(exp_t'{side: OWN_I, data: 16'hBEEF});
        i_req = 1'b1; i_addr = 16'h0010;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                total_cnt++;
                if ({cyc[3:0], mem_wr, mem_addr, mem_wdata} !== {4'd1, 1'b0, 16'h0010, 16'h0000})
                    $display("FAIL i_read_mem_port: got cyc=%0d wr=%b addr=%h wdata=%h want cyc=1 wr=0 addr=0010 wdata=0000",
                             cyc, mem_wr, mem_addr, mem_wdata);
                else pass_cnt++;
            end
            if (i_stall !== (cyc <= 4)) stall_ok = 1'b0;
            if (i_done) begin
                done_cyc = cyc;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL i_read_sb: got unexpected i_done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = OWN_I; got.data = i_rdata;
                    if (got !== e) $display("FAIL i_read_data: got %h want %h", got, e); else pass_cnt++;
                end
            end
            step();
            if (done_cyc == cyc) i_req = 1'b0;
        end
        total_cnt++;
        if (en_cnt !== 1) $display("FAIL i_read_en_count: got %0d want 1", en_cnt); else pass_cnt++;
        total_cnt++;
        if (done_cyc !== LAT + 1) $display("FAIL i_read_done_cycle: got %0d want %0d", done_cyc, LAT + 1); else pass_cnt++;
        total_cnt++;
        if (!stall_ok) $display("FAIL i_read_stall: got bad i_stall want high in cycles 0-4 only"); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (i_rdata !== 16'hBEEF) $display("FAIL i_read_hold: got %h want beef", i_rdata); else pass_cnt++;
        step();
    endtask

    task automatic test_d_write();
        int   en_cnt;
        int   done_cyc;
        bit   stall_ok;
        exp_t e;
        exp_t got;
        en_cnt = 0; done_cyc = -1; stall_ok = 1'b1;
        sb.delete();
        sb.push_back(exp_t'{side: OWN_D, data: 16'h0000});
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                total_cnt++;
                if ({cyc[3:0], mem_wr, mem_addr, mem_wdata} !== {4'd1, 1'b1, 16'h0200, 16'h1234})
                    $display("FAIL d_write_mem_port: got cyc=%0d wr=%b addr=%h wdata=%h want cyc=1 wr=1 addr=0200 wdata=1234",
                             cyc, mem_wr, mem_addr, mem_wdata);
                else pass_cnt++;
            end
            if (d_stall !== (cyc <= 4)) stall_ok = 1'b0;
            if (d_done) begin
                done_cyc = cyc;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL d_write_sb: got unexpected d_done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = OWN_D; got.data = d_rdata;
                    if (got !== e) $display("FAIL d_write_rdata: got %h want %h", got, e); else pass_cnt++;
                end
            end
            step();
            if (done_cyc == cyc) begin
                d_req = 1'b0; d_wr = 1'b0;
            end
        end
        total_cnt++;
        if (en_cnt !== 1) $display("FAIL d_write_en_count: got %0d want 1", en_cnt); else pass_cnt++;
        total_cnt++;
        if (done_cyc !== LAT + 1) $display("FAIL d_write_done_cycle: got %0d want %0d", done_cyc, LAT + 1); else pass_cnt++;
        total_cnt++;
        if (!stall_ok) $display("FAIL d_write_stall: got bad d_stall want high in cycles 0-4 only"); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int   d_cyc;
        int   i_cyc;
        bit   stall_ok;
        exp_t e;
        exp_t got;
        d_cyc = -1; i_cyc = -1; stall_ok = 1'b1;
        sb.delete();
        sb.push_back(exp_t'{side: OWN_D, data: mem_fn(16'h0300)});
        sb.push_back(exp_t'{side: OWN_I, data: mem_fn(16'h0040)});
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        for (int cyc = 0; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (i_stall !== (cyc <= 10)) stall_ok = 1'b0;
            if (d_done || i_done) begin
                if (d_done) d_cyc = cyc;
                if (i_done) i_cyc = cyc;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL simul_sb: got unexpected done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = i_done ? OWN_I : OWN_D;
                    got.data = i_done ? i_rdata : d_rdata;
                    if (got !== e) $display("FAIL simul_order: got %h want %h", got, e); else pass_cnt++;
                end
            end
            step();
            if (d_cyc == cyc) d_req = 1'b0;
            if (i_cyc == cyc) i_req = 1'b0;
        end
        total_cnt++;
        if (d_cyc !== LAT + 1) $display("FAIL simul_d_cycle: got %0d want %0d", d_cyc, LAT + 1); else pass_cnt++;
        total_cnt++;
        if (i_cyc !== 2 * LAT + 3) $display("FAIL simul_i_cycle: got %0d want %0d", i_cyc, 2 * LAT + 3); else pass_cnt++;
        total_cnt++;
        if (!stall_ok) $display("FAIL simul_i_stall: got bad i_stall want high in cycles 0-10"); else pass_cnt++;
    endtask

    task automatic test_starvation();
        owner_t order [6];
        int     want_i;
        int     ndone;
        int     i_pulses;
        exp_t   e;
        exp_t   got;
        ndone = 0; i_pulses = 0;
`ifdef ARB_STARVE_GUARD_EN
        order  = '{OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_I};
        want_i = 2;
`else
        order  = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_D, OWN_D};
        want_i = 0;
`endif
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            sb.push_back(exp_t'{side: order[k], data: (order[k] == OWN_I) ? mem_fn(16'h0060) : mem_fn(16'h0500)});
        end
        i_req = 1'b1; i_addr = 16'h0060;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
        for (int cyc = 0; cyc < 6 * (LAT + 2) + 6 && ndone < 6; cyc++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                ndone++;
                if (i_done) i_pulses++;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL starve_sb: got unexpected done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = i_done ? OWN_I : OWN_D;
                    got.data = i_done ? i_rdata : d_rdata;
                    if (got !== e) $display("FAIL starve_grant_%0d: got %h want %h", ndone, got, e); else pass_cnt++;
                end
            end
            step();
            if (ndone == 6) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        total_cnt++;
        if (ndone !== 6) $display("FAIL starve_count: got %0d dones want 6", ndone); else pass_cnt++;
        total_cnt++;
        if (i_pulses !== want_i) $display("FAIL starve_i_pulses: got %0d want %0d", i_pulses, want_i); else pass_cnt++;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        bit   no_done;
        int   done_cyc;
        exp_t e;
        exp_t got;
        no_done = 1'b1; done_cyc = -1;
        sb.delete();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (d_done) no_done = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (outs0 !== 70'd0) $display("FAIL reset_mid_outputs: got %h want 0", outs0); else pass_cnt++;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (d_done || i_done) no_done = 1'b0;
            step();
            @(negedge clk);
        end
        total_cnt++;
        if (!no_done) $display("FAIL reset_mid_no_done: got a done pulse want none"); else pass_cnt++;
        step();
        sb.push_back(exp_t'{side: OWN_I, data: mem_fn(16'h0080)});
        i_req = 1'b1; i_addr = 16'h0080;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (i_done) begin
                done_cyc = cyc;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL reset_mid_sb: got unexpected i_done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = OWN_I; got.data = i_rdata;
                    if (got !== e) $display("FAIL reset_mid_fresh_data: got %h want %h", got, e); else pass_cnt++;
                end
            end
            step();
            if (done_cyc == cyc) i_req = 1'b0;
        end
        total_cnt++;
        if (done_cyc !== LAT + 1) $display("FAIL reset_mid_fresh_cycle: got %0d want %0d", done_cyc, LAT + 1); else pass_cnt++;
    endtask

    task automatic test_lat1();
        int   en_cyc;
        int   done_cyc;
        exp_t e;
        exp_t got;
        en_cyc = -1; done_cyc = -1;
        sb.delete();
        sb.push_back(exp_t'{side: OWN_D, data: mem_fn(16'h0900)});
        d_req1 = 1'b1; d_wr1 = 1'b0; d_addr1 = 16'h0900;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (mem_en1) en_cyc = cyc;
            if (d_done1) begin
                done_cyc = cyc;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL lat1_sb: got unexpected d_done want none");
                end else begin
                    e = sb.pop_front();
                    got.side = OWN_D; got.data = d_rdata1;
                    if (got !== e) $display("FAIL lat1_data: got %h want %h", got, e); else pass_cnt++;
                end
            end
            step();
            if (done_cyc == cyc) d_req1 = 1'b0;
        end
        total_cnt++;
        if (en_cyc !== 1) $display("FAIL lat1_en_cycle: got %0d want 1", en_cyc); else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 2) $display("FAIL lat1_done_cycle: got %0d want 2", done_cyc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_lat1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
